// File: rtl/inv_sqrt_fixed.sv
// inv_sqrt_fixed: iterative unsigned fixed-point y = 1/sqrt(x), integer root then restoring divide.
// Optional sat_out flag port when INV_SQRT_SAT_FLAG_EN is defined.
module inv_sqrt_fixed #(
   parameter int INT_WIDTH   = 4,
   parameter int FRACT_WIDTH = 28
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [INT_WIDTH+FRACT_WIDTH-1:0]     data_in,
   input  logic                                 valid_in,
   output logic                                 ready_in,
   output logic [INT_WIDTH+FRACT_WIDTH-1:0]     data_out,
   output logic                                 valid_out,
   input  logic                                 ready_out
`ifdef INV_SQRT_SAT_FLAG_EN
   ,
   output logic                                 sat_out
`endif
);

   localparam int W    = INT_WIDTH + FRACT_WIDTH;
   localparam int F    = FRACT_WIDTH;
   localparam int RADW = W + F;
   localparam int NS   = (RADW + 1) / 2;
   localparam int RADP = 2 * NS;
   localparam int ND   = 2 * F + 1;
   localparam int RW   = NS + 2;
   localparam int CW   = $clog2(ND + 1);

   typedef enum logic [1:0] {
      IDLE,
      SQRT,
      DIV,
      DONE
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [RADP-1:0] rad_q;
   logic [NS-1:0]   root_q;
   logic [RW-1:0]   rem_q;
   logic [ND-1:0]   quo_q;
   logic            ready_in_q;
   logic            valid_out_q;
   logic [W-1:0]    data_out_q;

   logic [RW+1:0]   sq_rem_t;
   logic [RW+1:0]   sq_trial;
   logic            sq_ge;
   logic [RW-1:0]   sq_rem_d;
   logic [RW-1:0]   dv_r;
   logic [RW-1:0]   dv_s;
   logic            dv_ge;
   logic [RW-1:0]   dv_rem_d;
   logic            sat_d;
   logic [W-1:0]    res_d;

   always_comb begin
      sq_rem_t = {rem_q, rad_q[RADP-1 -: 2]};
      sq_trial = {{(RW-NS){1'b0}}, root_q, 2'b01};
      sq_ge    = (sq_rem_t >= sq_trial);
      sq_rem_d = sq_ge ? RW'(sq_rem_t - sq_trial) : RW'(sq_rem_t);

      // Remainder stays below the divisor, so its top bit is free to shift.
      dv_r     = {rem_q[RW-2:0], quo_q[ND-1]};
      dv_s     = {{(RW-NS){1'b0}}, root_q};
      dv_ge    = (dv_r >= dv_s);
      dv_rem_d = dv_ge ? (dv_r - dv_s) : dv_r;

      sat_d    = (root_q == '0) || (|quo_q[ND-1:W]);
      res_d    = sat_d ? {W{1'b1}} : quo_q[W-1:0];
   end

`ifdef INV_SQRT_SAT_FLAG_EN
   logic sat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q <= 1'b0;
      end else if (state_q == DONE && !valid_out_q) begin
         sat_q <= sat_d;
      end
   end

   assign sat_out = sat_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rad_q       <= '0;
         root_q      <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         ready_in_q  <= 1'b1;
         valid_out_q <= 1'b0;
         data_out_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (valid_in && ready_in_q) begin
                  rad_q      <= RADP'({data_in, {F{1'b0}}});
                  root_q     <= '0;
                  rem_q      <= '0;
                  cnt_q      <= '0;
                  ready_in_q <= 1'b0;
                  state_q    <= SQRT;
               end
            end
            SQRT: begin
               rad_q  <= {rad_q[RADP-3:0], 2'b00};
               root_q <= {root_q[NS-2:0], sq_ge};
               rem_q  <= sq_rem_d;
               if (cnt_q == CW'(NS - 1)) begin
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  quo_q   <= {1'b1, {(ND-1){1'b0}}};
                  state_q <= DIV;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DIV: begin
               rem_q <= dv_rem_d;
               quo_q <= {quo_q[ND-2:0], dv_ge};
               if (cnt_q == CW'(ND - 1)) begin
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (!valid_out_q) begin
                  data_out_q  <= res_d;
                  valid_out_q <= 1'b1;
               end else if (ready_out) begin
                  valid_out_q <= 1'b0;
                  ready_in_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_in  = ready_in_q;
   assign valid_out = valid_out_q;
   assign data_out  = data_out_q;

endmodule

// File: tb/tb_inv_sqrt_fixed.sv
// tb_inv_sqrt_fixed: directed and randomized checks of inv_sqrt_fixed
// against an arithmetic reference model.
module tb_inv_sqrt_fixed;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        ready_in;
   logic [31:0] data_out;
   logic        valid_out;
   logic        ready_out = 1'b0;
`ifdef INV_SQRT_SAT_FLAG_EN
   logic        sat_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   inv_sqrt_fixed #(
      .INT_WIDTH  (4),
      .FRACT_WIDTH(28)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .valid_in (valid_in),
      .ready_in (ready_in),
      .data_out (data_out),
      .valid_out(valid_out),
      .ready_out(ready_out)
`ifdef INV_SQRT_SAT_FLAG_EN
      ,
      .sat_out  (sat_o)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // y = floor(2^56 / floor(sqrt(x * 2^28))), saturated to 32 bits
   function automatic logic [31:0] model(input logic [31:0] x,
                                         output bit sat);
      longint unsigned rad, lo, hi, mid, q;
      rad = {32'd0, x} << 28;
      lo  = 0;
      hi  = 64'd1 << 30;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= rad) lo = mid;
         else hi = mid;
      end
      if (lo == 0) begin
         sat = 1'b1;
         return 32'hFFFF_FFFF;
      end
      q = (64'd1 << 56) / lo;
      sat = (q > 64'h0000_0000_FFFF_FFFF);
      return sat ? 32'hFFFF_FFFF : q[31:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input logic [31:0] x, input logic pre_rdy,
                          output int lat);
      data_in   = x;
      valid_in  = 1'b1;
      ready_out = pre_rdy;
      step();
      valid_in = 1'b0;
      data_in  = $urandom;
      lat = 0;
      while (!valid_out && lat < 200) begin
         step();
         lat++;
      end
   endtask

   task automatic consume(input int stall);
      if (stall > 0) ready_out = 1'b0;
      repeat (stall) step();
      ready_out = 1'b1;
      step();
      ready_out = 1'b0;
      chk("hs_valid_out", valid_out, 1'b0);
      chk("hs_ready_in", ready_in, 1'b1);
   endtask

   task automatic check_res(input string tag, input logic [31:0] x,
                            input int lat);
      logic [31:0] e;
      bit          es;
      e = model(x, es);
      chk({tag, "_lat"}, lat, 88);
      chk({tag, "_data"}, data_out, e);
`ifdef INV_SQRT_SAT_FLAG_EN
      chk({tag, "_sat"}, sat_o, es);
`endif
   endtask

   initial begin : main
      int          lat;
      logic [31:0] x;
      logic [31:0] ex;
      logic [31:0] dx [4];
      logic [31:0] dy [4];

      // Reset state
      step();
      step();
      chk("rst_ready_in", ready_in, 1'b1);
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_data_out", data_out, 32'h0);
`ifdef INV_SQRT_SAT_FLAG_EN
      chk("rst_sat", sat_o, 1'b0);
`endif
      rst_n = 1'b1;
      step();

      // Directed values, including the saturating corner cases
      dx = '{32'h1000_0000, 32'h4000_0000, 32'h0400_0000, 32'h0};
      dy = '{32'h1000_0000, 32'h0800_0000, 32'h2000_0000, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) begin
         chk("dir_ready_in", ready_in, 1'b1);
         run_req(dx[i], 1'b0, lat);
         chk("dir_lat", lat, 88);
         chk("dir_data", data_out, dy[i]);
         check_res("dir_model", dx[i], lat);
         consume(0);
         step();
      end
      run_req(32'h1, 1'b1, lat);
      chk("one_data", data_out, 32'hFFFF_FFFF);
`ifdef INV_SQRT_SAT_FLAG_EN
      chk("one_sat", sat_o, 1'b1);
`endif
      check_res("one", 32'h1, lat);
      consume(0);

      // Response hold under back-pressure; valid_in ignored while busy
      x = 32'h0900_0000;
      run_req(x, 1'b0, lat);
      chk("hold_data0", data_out, 32'h1555_5555);
      for (int c = 0; c < 10; c++) begin
         valid_in = (c == 3);
         data_in  = 32'h1000_0000;
         step();
         valid_in = 1'b0;
         chk("hold_valid", valid_out, 1'b1);
         chk("hold_data", data_out, 32'h1555_5555);
         chk("hold_ready_in", ready_in, 1'b0);
      end
      // valid_in in the handshake cycle must not be taken
      ready_out = 1'b1;
      valid_in  = 1'b1;
      step();
      valid_in  = 1'b0;
      ready_out = 1'b0;
      chk("hs2_valid_out", valid_out, 1'b0);
      chk("hs2_ready_in", ready_in, 1'b1);
      chk("hs2_data_kept", data_out, 32'h1555_5555);
      step();
      step();
      chk("idle_ready_in", ready_in, 1'b1);
      chk("idle_valid_out", valid_out, 1'b0);

      // Asynchronous reset in the middle of the root phase
      data_in  = 32'h2345_6789;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      repeat (5) step();
      chk("mid_busy", ready_in, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_ready_in", ready_in, 1'b1);
      chk("arst_valid_out", valid_out, 1'b0);
      chk("arst_data_out", data_out, 32'h0);
`ifdef INV_SQRT_SAT_FLAG_EN
      chk("arst_sat", sat_o, 1'b0);
`endif
      step();
      rst_n = 1'b1;
      step();
      x = 32'h0123_4567;
      run_req(x, 1'b0, lat);
      check_res("post_rst", x, lat);
      ex = model(x, ex[0]);
      consume(2);

      // Randomized back-to-back traffic with random consumer stalls
      for (int i = 0; i < 600; i++) begin
         x = $urandom >> $urandom_range(0, 31);
         if (!ready_in) step();
         chk("rnd_ready_in", ready_in, 1'b1);
         run_req(x, 1'($urandom_range(0, 1)), lat);
         check_res("rnd", x, lat);
         consume($urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
